// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, bit indices and FSM state types for iobus_uart
package uart_pkg;

  localparam logic [31:0] REG_DATA_OFF   = 32'h0;
  localparam logic [31:0] REG_STATUS_OFF = 32'h4;
  localparam logic [31:0] REG_CTRL_OFF   = 32'h8;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  localparam int CTRL_RX_IE  = 0;
  localparam int CTRL_TXE_IE = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/iobus_uart_fifo.sv
// rtl/iobus_uart_fifo.sv - small synchronous FIFO feeding the UART transmitter
module iobus_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // At full a same-edge pop frees the slot being written, so both are taken.
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping; reset discards any queued bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iobus_uart.sv
// rtl/iobus_uart.sv - memory-mapped 8N1 UART with TX FIFO, RX holding register and interrupt
module iobus_uart
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int          TX_DEPTH     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  input  logic        SER_RX,
  output logic        SER_TX,
  output logic        INTR
);

  localparam logic [31:0] A_DATA    = BASE_ADDR + REG_DATA_OFF;
  localparam logic [31:0] A_STATUS  = BASE_ADDR + REG_STATUS_OFF;
  localparam logic [31:0] A_CTRL    = BASE_ADDR + REG_CTRL_OFF;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic       wr_data, wr_status, wr_ctrl;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_dout;
  tx_state_t  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  logic       tx_empty;
  logic [1:0] rx_sync;
  logic       rx_s;
  rx_state_t  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic       rx_err_wait;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, frame_err;
  logic       rx_stop_sample, rx_good, rx_bad, valid_kept, rx_load;
  logic [1:0] ctrl;
  logic [31:0] status;

  assign wr_data   = IOBUS_WR & (IOBUS_ADDR == A_DATA);
  assign wr_status = IOBUS_WR & (IOBUS_ADDR == A_STATUS);
  assign wr_ctrl   = IOBUS_WR & (IOBUS_ADDR == A_CTRL);

  // Pop when a new frame is launched, either from idle or straight out of a stop bit.
  assign fifo_pop = ~fifo_empty &
                    ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_cnt == BIT_LAST)));
  assign tx_empty = fifo_empty & (tx_state == TX_IDLE);

  iobus_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (IOBUS_OUT[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Transmit state machine; SER_TX is a flop so it resets high asynchronously.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      SER_TX   <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (!fifo_empty) begin
          tx_state <= TX_START;
          tx_shift <= fifo_dout;
          tx_cnt   <= '0;
          SER_TX   <= 1'b0;
        end
        TX_START: if (tx_cnt == BIT_LAST) begin
          tx_state <= TX_DATA;
          tx_cnt   <= '0;
          tx_bit   <= '0;
          SER_TX   <= tx_shift[0];
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP;
            SER_TX   <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            SER_TX   <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_STOP: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (!fifo_empty) begin
            tx_state <= TX_START;
            tx_shift <= fifo_dout;
            SER_TX   <= 1'b0;
          end else tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + 16'd1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer on the asynchronous serial input, idling high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], SER_RX};
  end
  assign rx_s = rx_sync[1];

  // Receive state machine: mid-bit sampling, false-start rejection, wait-high after a bad stop bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_err_wait <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
        end
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else                rx_bit   <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_STOP: if (rx_err_wait) begin
          if (rx_s) begin
            rx_state    <= RX_IDLE;
            rx_err_wait <= 1'b0;
          end
        end else if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          if (rx_s) rx_state    <= RX_IDLE;
          else      rx_err_wait <= 1'b1;
        end else rx_cnt <= rx_cnt + 16'd1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_stop_sample = (rx_state == RX_STOP) & ~rx_err_wait & (rx_cnt == BIT_LAST);
  assign rx_good        = rx_stop_sample & rx_s;
  assign rx_bad         = rx_stop_sample & ~rx_s;
  // A same-edge clear of rx_valid frees the holding register for the arriving byte.
  assign valid_kept     = rx_valid & ~(wr_status & IOBUS_OUT[ST_RX_VALID]);
  assign rx_load        = rx_good & ~valid_kept;

  // Receive holding register and sticky status flags; hardware set wins over a same-edge clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_load) rx_data <= rx_shift;
      rx_valid   <= rx_load | valid_kept;
      rx_overrun <= (rx_good & valid_kept) |
                    (rx_overrun & ~(wr_status & IOBUS_OUT[ST_RX_OVERRUN]));
      frame_err  <= rx_bad | (frame_err & ~(wr_status & IOBUS_OUT[ST_FRAME_ERR]));
    end
  end

  // Interrupt enables.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         ctrl <= '0;
    else if (wr_ctrl) ctrl <= IOBUS_OUT[1:0];
  end

  // Registered level interrupt.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) INTR <= 1'b0;
    else      INTR <= (rx_valid & ctrl[CTRL_RX_IE]) | (tx_empty & ctrl[CTRL_TXE_IE]);
  end

  // STATUS word assembly.
  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err;
  end

  // Combinational read mux; undecoded addresses read zero.
  always_comb begin
    IOBUS_IN = '0;
    case (IOBUS_ADDR)
      A_DATA:   IOBUS_IN = {24'b0, rx_data};
      A_STATUS: IOBUS_IN = status;
      A_CTRL:   IOBUS_IN = {30'b0, ctrl};
      default:  IOBUS_IN = '0;
    endcase
  end

endmodule

// File: tb/tb_iobus_uart.sv
// tb/tb_iobus_uart.sv - self-checking bench for iobus_uart
module tb_iobus_uart;

  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        CLK, RST, IOBUS_WR, SER_RX, SER_TX, INTR;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  int total = 0;
  int bad   = 0;

  iobus_uart #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .TX_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .SER_RX(SER_RX),
    .SER_TX(SER_TX), .INTR(INTR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_intr;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr;
    #1 data = IOBUS_IN;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge CLK);
    SER_RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      SER_RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    SER_RX = stop_bit;
    repeat (CPB) @(negedge CLK);
    SER_RX = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  // Returns at the middle of the stop bit; gap counts negedges until the start bit was seen.
  task automatic tx_capture(output logic [7:0] b, output int gap, output logic frame_ok);
    gap = 0;
    b = 8'h00;
    frame_ok = 1'b0;
    while (SER_TX !== 1'b0 && gap < 400) begin
      @(negedge CLK);
      gap++;
    end
    if (gap >= 400) begin
      total++;
      bad++;
      $display("FAIL tx_start_wait: no start bit within 400 cycles");
    end else begin
      repeat (CPB / 2) @(negedge CLK);
      frame_ok = (SER_TX === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge CLK);
        b[i] = SER_TX;
      end
      repeat (CPB) @(negedge CLK);
      frame_ok = frame_ok & (SER_TX === 1'b1);
    end
  endtask

  logic [31:0] rd;
  logic [7:0]  tb_byte;
  logic        tb_ok;
  int          tb_gap;
  int          lows;

  initial begin
    RST = 1'b0; SER_RX = 1'b1; IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0; IOBUS_OUT = 32'h0;
    vecs[0]  = '{1'b0, BASE + 32'h0,  32'h0,         32'h0, 1'b0};
    vecs[1]  = '{1'b0, BASE + 32'h4,  32'h0,         32'h2, 1'b0};
    vecs[2]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h0, 1'b0};
    vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,         32'h0, 1'b0};
    vecs[4]  = '{1'b0, BASE + 32'h1,  32'h0,         32'h0, 1'b0};
    vecs[5]  = '{1'b0, BASE - 32'h4,  32'h0,         32'h0, 1'b0};
    vecs[6]  = '{1'b1, BASE + 32'h8,  32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h3, 1'b1};
    vecs[8]  = '{1'b1, BASE + 32'h8,  32'h0000_0002, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h2, 1'b1};
    vecs[10] = '{1'b1, BASE + 32'h4,  32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[11] = '{1'b0, BASE + 32'h4,  32'h0,         32'h2, 1'b1};
    vecs[12] = '{1'b1, BASE + 32'h8,  32'h0,         32'h0, 1'b0};
    vecs[13] = '{1'b0, BASE + 32'h8,  32'h0,         32'h0, 1'b0};
    vecs[14] = '{1'b1, BASE + 32'hC,  32'h0000_00A5, 32'h0, 1'b0};
    vecs[15] = '{1'b0, BASE + 32'h4,  32'h0,         32'h2, 1'b0};
    vecs[16] = '{1'b0, BASE + 32'h0,  32'h0,         32'h0, 1'b0};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_ser_tx", {31'b0, SER_TX}, 32'h1);
    chk("rst_intr", {31'b0, INTR}, 32'h0);
    bus_read(BASE + 32'h4, rd);
    chk("rst_status", rd, 32'h2);
    @(negedge CLK);
    RST = 1'b1;

    // Register map vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        chk($sformatf("vec%0d_intr", i), {31'b0, INTR}, {31'b0, vecs[i].exp_intr});
      end
    end

    // Single frame 0xA5: start bit on the edge after the write
    bus_write(BASE, 32'hA5);
    chk("a5_idle_before_start", {31'b0, SER_TX}, 32'h1);
    tx_capture(tb_byte, tb_gap, tb_ok);
    chk("a5_latency", tb_gap, 1);
    chk("a5_byte", {24'b0, tb_byte}, 32'hA5);
    chk("a5_framing", {31'b0, tb_ok}, 32'h1);
    repeat (CPB) @(negedge CLK);
    bus_read(BASE + 32'h4, rd);
    chk("a5_tx_empty_after", rd, 32'h2);

    // Burst of five writes behind an active frame: the fifth is dropped
    fork
      begin
        bus_write(BASE, 32'h01);
        for (int i = 0; i < 5; i++) begin
          @(negedge CLK);
          IOBUS_ADDR = BASE;
          IOBUS_OUT  = 32'h02 + 32'(i);
          IOBUS_WR   = 1'b1;
        end
        @(negedge CLK);
        IOBUS_WR = 1'b0;
        bus_read(BASE + 32'h4, rd);
        chk("burst_full", rd, 32'h1);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          tx_capture(tb_byte, tb_gap, tb_ok);
          chk($sformatf("burst_byte%0d", k), {24'b0, tb_byte}, 32'h01 + 32'(k));
          chk($sformatf("burst_frame%0d", k), {31'b0, tb_ok}, 32'h1);
          if (k > 0) chk($sformatf("burst_gap%0d", k), tb_gap, CPB / 2);
        end
      end
    join
    lows = 0;
    repeat (60) begin
      @(negedge CLK);
      if (SER_TX !== 1'b1) lows++;
    end
    chk("burst_no_sixth_frame", lows, 0);
    bus_read(BASE + 32'h4, rd);
    chk("burst_empty_after", rd, 32'h2);

    // Receive 0x3C with rx_ie set
    bus_write(BASE + 32'h8, 32'h1);
    send_rx(8'h3C, 1'b1);
    bus_read(BASE + 32'h4, rd);
    chk("rx3c_status", rd, 32'h6);
    bus_read(BASE, rd);
    chk("rx3c_data", rd, 32'h3C);
    chk("rx3c_intr", {31'b0, INTR}, 32'h1);
    bus_write(BASE + 32'h4, 32'h4);
    chk("rx3c_intr_lag", {31'b0, INTR}, 32'h1);
    @(negedge CLK);
    chk("rx3c_intr_clear", {31'b0, INTR}, 32'h0);

    // Overrun: 0x11 then 0x22 without clearing
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(BASE, rd);
    chk("ovr_data", rd, 32'h11);
    bus_read(BASE + 32'h4, rd);
    chk("ovr_status", rd, 32'hE);
    bus_write(BASE + 32'h4, 32'h8);

    // Clear of rx_valid on the same edge as a new byte completes
    fork
      send_rx(8'h5A, 1'b1);
      begin
        @(negedge CLK);
        repeat (154) @(negedge CLK);
        IOBUS_ADDR = BASE + 32'h4;
        IOBUS_OUT  = 32'h4;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = 32'h0;
      end
    join
    bus_read(BASE, rd);
    chk("sameedge_data", rd, 32'h5A);
    bus_read(BASE + 32'h4, rd);
    chk("sameedge_status", rd, 32'h6);
    bus_write(BASE + 32'h4, 32'h1C);

    // Framing error, then an 8-cycle glitch
    send_rx(8'h77, 1'b0);
    bus_read(BASE + 32'h4, rd);
    chk("ferr_status", rd, 32'h12);
    bus_read(BASE, rd);
    chk("ferr_data_kept", rd, 32'h5A);
    bus_write(BASE + 32'h4, 32'h10);
    @(negedge CLK);
    SER_RX = 1'b0;
    repeat (8) @(negedge CLK);
    SER_RX = 1'b1;
    repeat (200) @(negedge CLK);
    bus_read(BASE + 32'h4, rd);
    chk("glitch_status", rd, 32'h2);
    bus_read(BASE, rd);
    chk("glitch_data", rd, 32'h5A);

    // Reset in the middle of a frame's data bits
    send_rx(8'h42, 1'b1);
    bus_write(BASE + 32'h8, 32'h3);
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'h55);
    repeat (40) @(negedge CLK);
    chk("midrst_tx_low", {31'b0, SER_TX}, 32'h0);
    chk("midrst_intr_high", {31'b0, INTR}, 32'h1);
    #2 RST = 1'b0;
    #1;
    chk("midrst_ser_tx", {31'b0, SER_TX}, 32'h1);
    chk("midrst_intr", {31'b0, INTR}, 32'h0);
    bus_read(BASE + 32'h4, rd);
    chk("midrst_status", rd, 32'h2);
    bus_read(BASE + 32'h8, rd);
    chk("midrst_ctrl", rd, 32'h0);
    bus_read(BASE, rd);
    chk("midrst_data", rd, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge CLK);
      if (SER_TX !== 1'b1) lows++;
    end
    chk("midrst_fifo_discarded", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iobus_uart.md
IOBUS_UART -- requirements
Module: iobus_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, CLK cycles per serial bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 Parameter BASE_ADDR, default 32'h1100_0100, word-aligned base of the 3-register window.
REQ-003 Parameter TX_DEPTH, default 4, TX FIFO entries (power of 2, 2..16).
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, asynchronous assert, active-low (RST=0 resets).
REQ-006 IOBUS_ADDR  input  32  CPU IO address (ALU result).
REQ-007 IOBUS_OUT  input  32  CPU write data (rs2).
REQ-008 IOBUS_WR  input  1  one-cycle write strobe.
REQ-009 IOBUS_IN  output  32  read data, combinational from ADDR; 0 when ADDR is outside the window.
REQ-010 SER_RX  input  1  asynchronous serial input, idle high.
REQ-011 SER_TX  output  1  serial output, idle high.
REQ-012 INTR  output  1  level interrupt request to the CPU.

Function
REQ-013 Register map: DATA=BASE+0, STATUS=BASE+4, CTRL=BASE+8; any other address is not decoded, so writes are ignored and reads return 0.
REQ-014 DATA write pushes IOBUS_OUT[7:0]; DATA read returns {24'b0, rx_data}, with no side effect on read.
REQ-015 STATUS read bits: [0] tx_full, [1] tx_empty (FIFO empty and TX FSM IDLE), [2] rx_valid, [3] rx_overrun, [4] frame_err, all others 0.
REQ-016 STATUS write is write-1-to-clear for bits [4:2]; bits [1:0] are read-only.
REQ-017 CTRL bits: [0] rx_ie, [1] txe_ie, both read/write; all others read 0.
REQ-018 Frame format: 8N1, LSB first, each bit held exactly CLKS_PER_BIT cycles.
REQ-019 TX FSM states: IDLE, START, DATA, STOP; IDLE->START when FIFO is non-empty (pop on that edge); START->DATA, DATA->STOP after bit 7, STOP->IDLE after one bit time.
REQ-020 TX latency: a DATA write sampled at edge N into an empty FIFO with the FSM in IDLE drives SER_TX=0 from edge N+1.
REQ-021 Back-to-back frames: if the FIFO is non-empty at the end of STOP, the next START follows with no idle cycle.
REQ-022 A push while the FIFO is full and no pop occurs on the same edge is dropped silently; a push and a pop on the same edge at full are both accepted.
REQ-023 RX path: SER_RX passes through a 2-flop synchronizer before any use.
REQ-024 RX FSM states: IDLE, START, DATA, STOP; a falling edge in IDLE enters START.
REQ-025 In START, the line is sampled at CLKS_PER_BIT/2; if it is high (false start), the FSM returns to IDLE.
REQ-026 Data bits and the stop bit are sampled at mid-bit, CLKS_PER_BIT after the previous sample.
REQ-027 Stop bit = 1 and rx_valid = 0: load rx_data and set rx_valid.
REQ-028 Stop bit = 1 and rx_valid = 1: keep the old rx_data and set rx_overrun.
REQ-029 Stop bit = 0: discard the byte, set frame_err, and return to IDLE only after SER_RX is high.
REQ-030 A STATUS clear of rx_valid on the same edge as a new byte completes: the new byte is loaded and rx_valid ends at 1.
REQ-031 INTR = (rx_valid & rx_ie) | (tx_empty & txe_ie), registered, so it lags its sources by one cycle.

Reset
REQ-032 On RST=0 both FSMs go to IDLE and all counters and FIFO pointers clear.
REQ-033 Reset values: rx_data=0, STATUS sticky bits=0, CTRL=0, SER_TX=1, INTR=0, synchronizer flops=1.
REQ-034 Reset asserted mid-frame aborts the frame immediately (SER_TX=1 asynchronously) and discards the FIFO contents.

Structure
REQ-035 Package uart_pkg holds the register offsets, STATUS/CTRL bit indices, and the tx_state_t/rx_state_t enums.
REQ-036 The TX FIFO is a sub-module iobus_uart_fifo (push, pop, full, empty, dout) instantiated once.

Verification (CLKS_PER_BIT=16)
REQ-037 Write 0xA5 to DATA from idle -> SER_TX low from the next edge; LSB-first bits 1,0,1,0,0,1,0,1 then stop, each 16 cycles; total frame 160 cycles.
REQ-038 Five DATA writes back-to-back at TX_DEPTH=4 while a frame is active -> the 5th write is dropped; 4 contiguous frames with no idle gap; tx_empty=1 afterwards.
REQ-039 Drive 0x3C on SER_RX -> rx_valid=1 and DATA reads 0x0000003C; with rx_ie=1, INTR=1; writing STATUS=0x4 clears INTR.
REQ-040 Two frames 0x11 then 0x22 with no clear between -> DATA=0x11, rx_overrun=1.
REQ-041 Stop bit forced 0 -> frame_err=1 and rx_valid=0; an 8-cycle low glitch on SER_RX -> no state change.
REQ-042 RST=0 in the middle of the DATA state -> SER_TX=1 and INTR=0 immediately; all STATUS and CTRL read their reset values.
